and_or_delay_model: RTL and testbench

//   Cycle-accurate timing model of the AND-OR function w = (a & b) | c.
//   Two lanes run side by side, each with its own per-gate rise/fall delays in clock cycles:
//   - lane 1: the gate-level cell.
//   - lane 3: the alternative cell.

---
 rtl/and_or_pkg.sv | 24 ++
 rtl/inertial_delay_stage.sv | 59 +++++
 rtl/and_or_delay_model.sv | 81 ++++++++
 tb/tb_and_or_delay_model.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/and_or_pkg.sv
// Shared types, default lane delays and the delay legality helper for the AND-OR timing model.
package and_or_pkg;

  localparam int unsigned DW = 8;

  typedef logic [DW-1:0] delay_t;

  localparam int unsigned L1_AND_R = 7;
  localparam int unsigned L1_AND_F = 5;
  localparam int unsigned L1_OR_R  = 12;
  localparam int unsigned L1_OR_F  = 12;
  localparam int unsigned L3_AND_R = 10;
  localparam int unsigned L3_AND_F = 8;
  localparam int unsigned L3_OR_R  = 10;
  localparam int unsigned L3_OR_F  = 10;

  // A delay must be non-zero and fit in a counter of width dw.
  function automatic bit legal_delay(input int unsigned d, input int unsigned dw);
    longint unsigned lim;
    lim = 64'd1 << dw;
    return (d != 0) && (64'(d) < lim);
  endfunction

endpackage

// File: rtl/inertial_delay_stage.sv
// Inertial delay: x must hold for RISE/FALL cycles before y follows; shorter pulses are absorbed.
module inertial_delay_stage
  import and_or_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned RISE = 1,
  parameter int unsigned FALL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic y,
  output logic busy,
  output logic y_nxt_c,
  output logic busy_nxt_c
);

  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;

  if (!(legal_delay(RISE, DW) && legal_delay(FALL, DW))) begin : g_bad_delay
    $error("inertial_delay_stage: RISE/FALL must be in 1..2**DW-1");
  end

  // Next-state: load on a new target, cancel if x returns, commit when the count runs out.
  always_comb begin
    y_nxt_c    = y;
    busy_nxt_c = busy;
    cnt_nxt    = cnt;
    if (busy) begin
      if (x == y) begin
        busy_nxt_c = 1'b0;
        cnt_nxt    = '0;
      end else if (cnt <= DW'(1)) begin
        y_nxt_c    = x;
        busy_nxt_c = 1'b0;
        cnt_nxt    = '0;
      end else begin
        cnt_nxt = cnt - DW'(1);
      end
    end else if (x != y) begin
      busy_nxt_c = 1'b1;
      cnt_nxt    = x ? DW'(RISE) : DW'(FALL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else begin
      y    <= y_nxt_c;
      busy <= busy_nxt_c;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/and_or_delay_model.sv
// Two-lane cycle-accurate timing model of w = (a & b) | c for comparing two cell implementations.
module and_or_delay_model
  import and_or_pkg::*;
#(
  parameter int unsigned DW     = and_or_pkg::DW,
  parameter int unsigned L1_AND_R = and_or_pkg::L1_AND_R,
  parameter int unsigned L1_AND_F = and_or_pkg::L1_AND_F,
  parameter int unsigned L1_OR_R  = and_or_pkg::L1_OR_R,
  parameter int unsigned L1_OR_F  = and_or_pkg::L1_OR_F,
  parameter int unsigned L3_AND_R = and_or_pkg::L3_AND_R,
  parameter int unsigned L3_AND_F = and_or_pkg::L3_AND_F,
  parameter int unsigned L3_OR_R  = and_or_pkg::L3_OR_R,
  parameter int unsigned L3_OR_F  = and_or_pkg::L3_OR_F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic w1,
  output logic w3,
  output logic settled1,
  output logic settled3,
  output logic mismatch
);

  if (!(legal_delay(L1_AND_R, DW) && legal_delay(L1_AND_F, DW) &&
        legal_delay(L1_OR_R, DW)  && legal_delay(L1_OR_F, DW)  &&
        legal_delay(L3_AND_R, DW) && legal_delay(L3_AND_F, DW) &&
        legal_delay(L3_OR_R, DW)  && legal_delay(L3_OR_F, DW))) begin : g_bad_delay
    $error("and_or_delay_model: every delay must be in 1..2**DW-1");
  end

  logic and_x;
  logic and1_y_unused, and1_busy, and1_y_nxt, and1_busy_nxt;
  logic and3_y_unused, and3_busy, and3_y_nxt, and3_busy_nxt;
  logic or1_x, or1_y, or1_busy, or1_y_nxt, or1_busy_nxt;
  logic or3_x, or3_y, or3_busy, or3_y_nxt, or3_busy_nxt;

  // OR stages see the AND output on the same edge it commits, so a/b latency is D_AND + D_OR.
  assign and_x = a & b;
  assign or1_x = and1_y_nxt | c;
  assign or3_x = and3_y_nxt | c;

  inertial_delay_stage #(.DW(DW), .RISE(L1_AND_R), .FALL(L1_AND_F)) u_and1 (
    .clk(clk), .rst_n(rst_n), .x(and_x), .y(and1_y_unused), .busy(and1_busy),
    .y_nxt_c(and1_y_nxt), .busy_nxt_c(and1_busy_nxt)
  );

  inertial_delay_stage #(.DW(DW), .RISE(L1_OR_R), .FALL(L1_OR_F)) u_or1 (
    .clk(clk), .rst_n(rst_n), .x(or1_x), .y(or1_y), .busy(or1_busy),
    .y_nxt_c(or1_y_nxt), .busy_nxt_c(or1_busy_nxt)
  );

  inertial_delay_stage #(.DW(DW), .RISE(L3_AND_R), .FALL(L3_AND_F)) u_and3 (
    .clk(clk), .rst_n(rst_n), .x(and_x), .y(and3_y_unused), .busy(and3_busy),
    .y_nxt_c(and3_y_nxt), .busy_nxt_c(and3_busy_nxt)
  );

  inertial_delay_stage #(.DW(DW), .RISE(L3_OR_R), .FALL(L3_OR_F)) u_or3 (
    .clk(clk), .rst_n(rst_n), .x(or3_x), .y(or3_y), .busy(or3_busy),
    .y_nxt_c(or3_y_nxt), .busy_nxt_c(or3_busy_nxt)
  );

  assign w1 = or1_y;
  assign w3 = or3_y;

  // Status flags track the stage next-state so they line up with w1/w3 in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled1 <= 1'b1;
      settled3 <= 1'b1;
      mismatch <= 1'b0;
    end else begin
      settled1 <= !(and1_busy_nxt || or1_busy_nxt);
      settled3 <= !(and3_busy_nxt || or3_busy_nxt);
      mismatch <= (or1_y_nxt != or3_y_nxt);
    end
  end

endmodule

// File: tb/tb_and_or_delay_model.sv
// Directed bench for the two-lane AND-OR delay model; expected timings computed by hand from the delays.
module tb_and_or_delay_model;

  logic clk;
  logic rst_n;
  logic a, b, c;
  logic w1, w3, settled1, settled3, mismatch;

  int checks   = 0;
  int failures = 0;

  and_or_delay_model dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .w1(w1), .w3(w3), .settled1(settled1), .settled3(settled3), .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_w1, input logic e_w3,
                         input logic e_s1, input logic e_s3, input logic e_mm);
    chk({tag, ".w1"}, w1, e_w1);
    chk({tag, ".w3"}, w3, e_w3);
    chk({tag, ".settled1"}, settled1, e_s1);
    chk({tag, ".settled3"}, settled3, e_s3);
    chk({tag, ".mismatch"}, mismatch, e_mm);
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    tick(2);
    chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 1: idle after reset release
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk_all("idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // 2: c rise, lane 3 after 10, lane 1 after 12
    c = 1'b1;
    tick(10);
    chk_all("c_rise_t9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("c_rise_t10", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk_all("c_rise_t11", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk_all("c_rise_t12", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    c = 1'b0;
    tick(10);
    chk_all("c_fall_t9", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("c_fall_t10", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk("c_fall_t11.mismatch", mismatch, 1'b1);
    tick(1);
    chk_all("c_fall_t12", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 3: a/b path, rise 19/20, fall 17/18
    b = 1'b1;
    tick(3);
    chk_all("b_only", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    a = 1'b1;
    tick(19);
    chk_all("ab_rise_t18", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("ab_rise_t19", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_all("ab_rise_t20", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    b = 1'b0;
    tick(17);
    chk_all("ab_fall_t16", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("ab_fall_t17", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_all("ab_fall_t18", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 4: 5-cycle c pulse is absorbed by both lanes
    c = 1'b1;
    tick(1);
    chk_all("pulse_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    c = 1'b0;
    tick(1);
    chk_all("pulse_cancel", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk_all("pulse_after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // 5: b toggling with a=0 causes no activity
    a = 1'b0;
    tick(3);
    b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_all("b_toggle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    b = 1'b0;
    tick(2);

    // 6: async reset mid-transition, then restart
    c = 1'b1;
    tick(4);
    chk("pre_reset.settled1", settled1, 1'b0);
    chk("pre_reset.settled3", settled3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(2);
    chk_all("in_reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(10);
    chk_all("post_reset_t9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("post_reset_t10", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    chk_all("post_reset_t12", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
